// File: rtl/ram_arbiter.sv
// Three-way SDRAM access arbiter: video, CPU and loader share one memory controller.
// One access at a time; fixed-length strobes, one-cycle done/ack, starvation override.
module ram_arbiter #(
   parameter int unsigned ADDR_W   = 21,
   parameter int unsigned ACC_CYC  = 6,
   parameter int unsigned MAX_WAIT = 3
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_ack,
   output logic [7:0]        vid_rdata,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic              cpu_ack,
   output logic [7:0]        cpu_rdata,
   input  logic              ld_req,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [7:0]        ld_wdata,
   output logic              ld_ack,
   output logic              mem_cs,
   output logic              mem_oe,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_din,
   input  logic [7:0]        mem_dout,
   output logic              busy
);

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ACC_CYC - 1);
   localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
   typedef enum logic [1:0] {P_NONE, P_VID, P_CPU, P_LD} port_t;

   state_t              state, state_d;
   port_t               win_c;
   port_t               grant;
   logic [CNT_W-1:0]    cnt;
   logic [WAIT_W-1:0]   lose_cpu, lose_ld;
   logic                rr_ld;

   // Arbitration: starved port first (CPU before loader), then video, then round-robin
   always_comb begin
      win_c = P_NONE;
      if (cpu_req && lose_cpu == WAIT_SAT)
         win_c = P_CPU;
      else if (ld_req && lose_ld == WAIT_SAT)
         win_c = P_LD;
      else if (vid_req)
         win_c = P_VID;
      else if (cpu_req && ld_req)
         win_c = rr_ld ? P_LD : P_CPU;
      else if (cpu_req)
         win_c = P_CPU;
      else if (ld_req)
         win_c = P_LD;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         state <= S_IDLE;
      else
         state <= state_d;
   end

   always_comb begin
      state_d = state;
      unique case (state)
         S_IDLE:   if (win_c != P_NONE) state_d = S_ACCESS;
         S_ACCESS: if (cnt == CNT_LAST) state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Datapath: capture the winner, drive strobes, return data and ack
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         grant     <= P_NONE;
         cnt       <= '0;
         lose_cpu  <= '0;
         lose_ld   <= '0;
         rr_ld     <= 1'b0;
         mem_cs    <= 1'b0;
         mem_oe    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_din   <= '0;
         busy      <= 1'b0;
         vid_ack   <= 1'b0;
         cpu_ack   <= 1'b0;
         ld_ack    <= 1'b0;
         vid_rdata <= '0;
         cpu_rdata <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (win_c != P_NONE) begin
                  grant  <= win_c;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  mem_cs <= 1'b1;
                  unique case (win_c)
                     P_VID: begin
                        mem_addr <= vid_addr;
                        mem_din  <= '0;
                        mem_oe   <= 1'b1;
                        mem_we   <= 1'b0;
                     end
                     P_CPU: begin
                        mem_addr <= cpu_addr;
                        mem_din  <= cpu_wdata;
                        mem_oe   <= !cpu_we;
                        mem_we   <= cpu_we;
                     end
                     P_LD: begin
                        mem_addr <= ld_addr;
                        mem_din  <= ld_wdata;
                        mem_oe   <= 1'b0;
                        mem_we   <= 1'b1;
                     end
                     default: ;
                  endcase
                  if (win_c == P_CPU || win_c == P_LD)
                     rr_ld <= !rr_ld;
                  // Lose counters saturate so a starved port keeps its claim
                  if (win_c == P_CPU)
                     lose_cpu <= '0;
                  else if (cpu_req && lose_cpu != WAIT_SAT)
                     lose_cpu <= lose_cpu + WAIT_W'(1);
                  if (win_c == P_LD)
                     lose_ld <= '0;
                  else if (ld_req && lose_ld != WAIT_SAT)
                     lose_ld <= lose_ld + WAIT_W'(1);
               end
            end
            S_ACCESS: begin
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_LAST) begin
                  mem_cs <= 1'b0;
                  mem_oe <= 1'b0;
                  mem_we <= 1'b0;
                  unique case (grant)
                     P_VID: begin
                        vid_ack   <= 1'b1;
                        vid_rdata <= mem_dout;
                     end
                     P_CPU: begin
                        cpu_ack <= 1'b1;
                        if (!mem_we) cpu_rdata <= mem_dout;
                     end
                     P_LD:    ld_ack <= 1'b1;
                     default: ;
                  endcase
               end
            end
            S_DONE: begin
               vid_ack <= 1'b0;
               cpu_ack <= 1'b0;
               ld_ack  <= 1'b0;
               busy    <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: stimulus queues expected accesses, a monitor
// checks each memory access and each ack against the queue head.
module tb_ram_arbiter;

   localparam int unsigned ADDR_W   = 21;
   localparam int unsigned ACC_CYC  = 6;
   localparam int unsigned MAX_WAIT = 3;
   localparam int          P_VID = 0, P_CPU = 1, P_LD = 2;

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic              vid_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0, ld_req = 1'b0;
   logic [ADDR_W-1:0] vid_addr = '0, cpu_addr = '0, ld_addr = '0;
   logic [7:0]        cpu_wdata = '0, ld_wdata = '0;
   logic [7:0]        mem_dout = 8'hEE;
   logic              vid_ack, cpu_ack, ld_ack, mem_cs, mem_oe, mem_we, busy;
   logic [7:0]        vid_rdata, cpu_rdata, mem_din;
   logic [ADDR_W-1:0] mem_addr;

   ram_arbiter #(.ADDR_W(ADDR_W), .ACC_CYC(ACC_CYC), .MAX_WAIT(MAX_WAIT)) dut (
      .clock(clock), .reset_n(reset_n),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
      .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      int                port;
      bit                we;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        din;
      logic [7:0]        rdata;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   bit   have_cur = 0;
   int   n_cmp = 0, n_err = 0;
   int   cyc = 0;
   int   cs_run = 0, oe_run = 0;
   bit   prev_cs = 0;
   int   ack_cnt[3] = '{0, 0, 0};
   logic [7:0] rd_val = 8'h00;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int port, input bit we, input logic [ADDR_W-1:0] addr,
                       input logic [7:0] din, input logic [7:0] rdata);
      exp_t e;
      e.port = port; e.we = we; e.addr = addr; e.din = din; e.rdata = rdata;
      exp_q.push_back(e);
   endtask

   always @(posedge clock) cyc++;

   // Memory model: read data is valid only during the final strobe cycle
   always @(negedge clock) begin
      if (mem_oe) oe_run++;
      else        oe_run = 0;
      mem_dout = (oe_run == ACC_CYC) ? rd_val : 8'hEE;
   end

   // Monitor
   always @(negedge clock) begin
      if (!reset_n) begin
         cs_run  = 0;
         prev_cs = 0;
      end else begin
         if (mem_cs) begin
            if (!prev_cs) begin
               have_cur = (exp_q.size() != 0);
               if (have_cur) cur = exp_q[0];
               else begin
                  n_cmp++; n_err++;
                  $display("FAIL unexpected_access: got access at 0x%0h, want none", mem_addr);
               end
            end
            if (have_cur) begin
               check("acc_addr", mem_addr, cur.addr);
               check("acc_dir", {mem_oe, mem_we}, {!cur.we, cur.we});
               if (cur.we) check("acc_din", mem_din, cur.din);
            end
            check("acc_busy", busy, 1);
            cs_run++;
         end
         prev_cs = mem_cs;
         if (vid_ack || cpu_ack || ld_ack) begin
            int p;
            check("ack_onehot", int'(vid_ack) + int'(cpu_ack) + int'(ld_ack), 1);
            p = vid_ack ? P_VID : (cpu_ack ? P_CPU : P_LD);
            ack_cnt[p]++;
            if (exp_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_ack: got ack on port %0d, want none", p);
            end else begin
               cur = exp_q.pop_front();
               check("ack_port", p, cur.port);
               check("strobe_len", cs_run, ACC_CYC);
               check("done_strobes", {mem_cs, mem_oe, mem_we}, 0);
               check("done_busy", busy, 1);
               if (!cur.we && p == P_VID) check("vid_rdata", vid_rdata, cur.rdata);
               if (!cur.we && p == P_CPU) check("cpu_rdata", cpu_rdata, cur.rdata);
            end
            cs_run = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_ack(input int port, input int limit, output int got);
      bit seen = 0;
      for (int i = 0; i < limit && !seen; i++) begin
         tick();
         if ((port == P_VID && vid_ack) || (port == P_CPU && cpu_ack) || (port == P_LD && ld_ack))
            seen = 1;
      end
      got = cyc;
      if (!seen) begin
         n_cmp++; n_err++;
         $display("FAIL ack_timeout: got no ack on port %0d in %0d cycles, want ack", port, limit);
      end
   endtask

   task automatic do_reset();
      vid_req = 0; cpu_req = 0; ld_req = 0;
      reset_n = 0;
      tick();
      tick();
      check("rst_strobes", {mem_cs, mem_oe, mem_we, busy}, 0);
      check("rst_acks", {vid_ack, cpu_ack, ld_ack}, 0);
      check("rst_data", {mem_addr, mem_din, vid_rdata, cpu_rdata}, 0);
      reset_n = 1;
   endtask

   task automatic settle(input string tag);
      for (int i = 0; i < 12; i++) tick();
      check({tag, "_queue_empty"}, exp_q.size(), 0);
      check({tag, "_idle_busy"}, busy, 0);
   endtask

   // Latencies count the IDLE cycle that samples the request as cycle 1
   initial begin
      int req_cyc, got, got2, base;

      do_reset();

      // CPU read alone
      tick();
      rd_val = 8'h5A;
      push(P_CPU, 0, 21'h00123, 8'h00, 8'h5A);
      cpu_addr = 21'h00123; cpu_we = 0; cpu_req = 1; req_cyc = cyc;
      wait_ack(P_CPU, 20, got);
      cpu_req = 0;
      check("t1_latency", got - req_cyc + 1, ACC_CYC + 2);
      settle("t1");
      check("t1_rdata_hold", cpu_rdata, 8'h5A);

      // Reset in the 3rd ACCESS cycle, request kept high through reset
      rd_val = 8'h33;
      push(P_CPU, 0, 21'h0ABCD, 8'h00, 8'h33);
      cpu_addr = 21'h0ABCD; cpu_req = 1;
      tick(); tick(); tick();
      check("t2_in_access", {busy, mem_oe}, 2'b11);
      #2 reset_n = 0;
      #1;
      check("t2_abort_strobes", {mem_cs, mem_oe, mem_we, busy}, 0);
      check("t2_abort_acks", {vid_ack, cpu_ack, ld_ack}, 0);
      check("t2_abort_data", {mem_addr, cpu_rdata}, 0);
      tick(); tick();
      reset_n = 1; req_cyc = cyc;
      wait_ack(P_CPU, 20, got);
      cpu_req = 0;
      check("t2_latency", got - req_cyc + 1, ACC_CYC + 2);
      settle("t2");

      // Request dropped mid-access still completes exactly once
      rd_val = 8'h99;
      base = ack_cnt[P_CPU];
      push(P_CPU, 0, 21'h00777, 8'h00, 8'h99);
      cpu_addr = 21'h00777; cpu_req = 1; req_cyc = cyc;
      tick(); tick(); tick();
      cpu_req = 0; cpu_addr = 21'h1FFFF;
      wait_ack(P_CPU, 20, got);
      check("t3_latency", got - req_cyc + 1, ACC_CYC + 2);
      settle("t3");
      check("t3_single_ack", ack_cnt[P_CPU] - base, 1);

      // Video and CPU together: video first, CPU one slot later
      do_reset();
      tick();
      rd_val = 8'hC3;
      push(P_VID, 0, 21'h1F00F, 8'h00, 8'hC3);
      push(P_CPU, 1, 21'h0000F, 8'h11, 8'h00);
      vid_addr = 21'h1F00F; cpu_addr = 21'h0000F; cpu_we = 1; cpu_wdata = 8'h11;
      vid_req = 1; cpu_req = 1; req_cyc = cyc;
      wait_ack(P_VID, 20, got);
      vid_req = 0;
      check("t4_vid_latency", got - req_cyc + 1, ACC_CYC + 2);
      wait_ack(P_CPU, 20, got2);
      cpu_req = 0;
      check("t4_cpu_after_vid", got2 - got, ACC_CYC + 2);
      settle("t4");

      // Video held continuously: CPU wins the 4th arbitration
      do_reset();
      tick();
      rd_val = 8'h6B;
      base = ack_cnt[P_VID];
      for (int i = 0; i < 3; i++) push(P_VID, 0, 21'h10000, 8'h00, 8'h6B);
      push(P_CPU, 1, 21'h00200, 8'h42, 8'h00);
      vid_addr = 21'h10000; cpu_addr = 21'h00200; cpu_we = 1; cpu_wdata = 8'h42;
      vid_req = 1; cpu_req = 1; req_cyc = cyc;
      wait_ack(P_CPU, 60, got);
      vid_req = 0; cpu_req = 0;
      check("t5_vid_before_cpu", ack_cnt[P_VID] - base, 3);
      check("t5_cpu_latency", got - req_cyc + 1, 4 * (ACC_CYC + 2));
      settle("t5");

      // CPU and loader held: strict alternation starting with CPU
      do_reset();
      tick();
      rd_val = 8'h77;
      for (int i = 0; i < 2; i++) begin
         push(P_CPU, 0, 21'h00456, 8'h00, 8'h77);
         push(P_LD, 1, 21'h1ABCD, 8'hA5, 8'h00);
      end
      cpu_addr = 21'h00456; cpu_we = 0; ld_addr = 21'h1ABCD; ld_wdata = 8'hA5;
      cpu_req = 1; ld_req = 1; req_cyc = cyc;
      wait_ack(P_CPU, 20, got);
      wait_ack(P_LD, 20, got);
      wait_ack(P_CPU, 20, got);
      wait_ack(P_LD, 20, got);
      cpu_req = 0; ld_req = 0;
      check("t6_total_latency", got - req_cyc + 1, 4 * (ACC_CYC + 2));
      settle("t6");

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test by 200000, want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
